// File: rtl/pattern_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector:
// state-width clog2 and the KMP next-state table builder.
package pattern_det_pkg;

  localparam int DEF_PAT_W = 4;
  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int MAX_PAT_W = 8;
  localparam int ENT_W = 4;
  localparam int TBL_W = 2 * MAX_PAT_W * ENT_W;

  function automatic int clog2(input int val);
    int r;
    r = 0;
    while ((1 << r) < val) r++;
    return r;
  endfunction

  // Pattern character i, counted from the first-received (MSB) bit.
  function automatic logic pat_bit(input logic [7:0] pat, input int pat_w, input int i);
    logic [7:0] sh;
    sh = pat >> (pat_w - 1 - i);
    return sh[0];
  endfunction

  // Longest suffix of (first st pattern bits, then b) that is a prefix of the pattern.
  function automatic int kmp_len(input logic [7:0] pat, input int pat_w, input int st, input logic b);
    int   best;
    int   j;
    logic ok;
    logic c;
    best = 0;
    for (int k = 1; k <= st + 1; k++) begin
      if (k <= pat_w) begin
        ok = 1'b1;
        for (int m = 0; m < k; m++) begin
          j = st + 1 - k + m;
          c = (j == st) ? b : pat_bit(pat, pat_w, j);
          if (c != pat_bit(pat, pat_w, m)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Entry (2*state + bit) holds the next matched length; PAT_W means a full match.
  function automatic logic [TBL_W-1:0] build_next_tbl(input logic [7:0] pat, input int pat_w);
    logic [TBL_W-1:0] t;
    t = '0;
    for (int s = 0; s < pat_w; s++) begin
      for (int b = 0; b < 2; b++) begin
        t = t | (TBL_W'(kmp_len(pat, pat_w, s, 1'(b))) << ((2 * s + b) * ENT_W));
      end
    end
    return t;
  endfunction

  // Longest proper suffix of the whole pattern that is also a prefix.
  function automatic int overlap_len(input logic [7:0] pat, input int pat_w);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < pat_w; k++) begin
      ok = 1'b1;
      for (int m = 0; m < k; m++) begin
        if (pat_bit(pat, pat_w, pat_w - k + m) != pat_bit(pat, pat_w, m)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/serial_pattern_detector.sv
// Serial MSB-first pattern detector with one-cycle detect pulse and saturating match counter.
// Define OVERLAP_DETECT_EN to resume from the pattern's self-overlap after a match.
//
// state | meaning
// 0     | no pattern bits matched
// k     | first k pattern bits matched (1..PAT_W-1)
module serial_pattern_detector
  import pattern_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN[PAT_W-1:0],
  parameter int               CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  input  logic                       din,
  output logic                       detect,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [clog2(PAT_W+1)-1:0]  state_o
);

  localparam int SW = clog2(PAT_W + 1);
  localparam logic [TBL_W-1:0] NEXT_TBL = build_next_tbl(8'(PATTERN), PAT_W);
`ifdef OVERLAP_DETECT_EN
  localparam int POST_MATCH = overlap_len(8'(PATTERN), PAT_W);
`else
  localparam int POST_MATCH = 0;
`endif

  logic [SW-1:0]    r_state;
  logic             r_detect;
  logic [CNT_W-1:0] r_cnt;

  logic [SW-1:0]    w_state_nxt;
  logic             w_match;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ENT_W-1:0] w_adv;

  always_comb begin
    w_state_nxt = r_state;
    w_match     = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_adv       = ENT_W'(NEXT_TBL >> (int'({r_state, din}) * ENT_W));
    if (din_valid) begin
      if (w_adv == ENT_W'(PAT_W)) begin
        w_match     = 1'b1;
        w_state_nxt = SW'(POST_MATCH);
        if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + 1'b1;
      end else begin
        w_state_nxt = SW'(w_adv);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= '0;
      r_detect <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_detect <= w_match;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign detect    = r_detect;
  assign match_cnt = r_cnt;
  assign state_o   = r_state;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Scoreboard bench for serial_pattern_detector (PATTERN=1011): 8-bit and 2-bit counter instances.
module tb_serial_pattern_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_valid;
  logic       din;
  logic       detect, detect_c2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_c2;
  logic [2:0] state_o, state_o_c2;

  always #5 clk = ~clk;

`ifdef OVERLAP_DETECT_EN
  localparam logic [2:0] OV = 3'd1;
`else
  localparam logic [2:0] OV = 3'd0;
`endif

  serial_pattern_detector #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .detect(detect), .match_cnt(match_cnt), .state_o(state_o)
  );

  serial_pattern_detector #(.CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
    .detect(detect_c2), .match_cnt(match_cnt_c2), .state_o(state_o_c2)
  );

  typedef struct packed {
    logic       det;
    logic [7:0] cnt;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("detect",       {7'd0, detect},       {7'd0, mon_e.det});
      check("match_cnt",    match_cnt,            mon_e.cnt);
      check("state_o",      {5'd0, state_o},      {5'd0, mon_e.st});
      check("detect_c2",    {7'd0, detect_c2},    {7'd0, mon_e.det});
      check("match_cnt_c2", {6'd0, match_cnt_c2}, (mon_e.cnt > 8'd3) ? 8'd3 : mon_e.cnt);
      check("state_o_c2",   {5'd0, state_o_c2},   {5'd0, mon_e.st});
    end
  end

  task automatic step(input logic v, input logic d, input logic r,
                      input logic det, input logic [7:0] cnt, input logic [2:0] st);
    din_valid = v;
    din       = d;
    rst       = r;
    exp_q.push_back('{det, cnt, st});
    @(posedge clk);
    #1;
  endtask

  initial begin
    din_valid = 1'b0;
    din       = 1'b0;
    rst       = 1'b1;
    #2;

    // single match
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 3);
    step(1, 1, 0, 1, 1, OV);
    step(0, 0, 0, 0, 1, OV);

    // overlapping stream 1011011
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 3);
    step(1, 1, 0, 1, 1, OV);
`ifdef OVERLAP_DETECT_EN
    step(1, 0, 0, 0, 1, 2);
    step(1, 1, 0, 0, 1, 3);
    step(1, 1, 0, 1, 2, 1);
    step(0, 0, 0, 0, 2, 1);
`else
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
`endif

    // KMP fallback 101011
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 3);
    step(1, 1, 0, 1, 1, OV);
    step(0, 0, 0, 0, 1, OV);

    // invalid gap holds state
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 3);
    step(1, 1, 0, 1, 1, OV);
    step(0, 0, 0, 0, 1, OV);

    // reset mid-pattern, overriding a completing bit
    step(0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 3);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // five matches: 8-bit counter reaches 5, 2-bit counter saturates at 3
    step(0, 0, 1, 0, 0, 0);
    for (int g = 1; g <= 5; g++) begin
      step(1, 1, 0, 0, 8'(g - 1), 1);
      step(1, 0, 0, 0, 8'(g - 1), 2);
      step(1, 1, 0, 0, 8'(g - 1), 3);
      step(1, 1, 0, 1, 8'(g), OV);
    end
    step(0, 0, 0, 0, 5, OV);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
